// File: rtl/lane_fetch_unit.sv
// lane_fetch_unit
// ---------------
// Multi-lane instruction-fetch front end. Each lane keeps its own program
// counter and issues addresses to a synchronous-read instruction memory. The
// returned word is presented with its PC on a valid/ready interface. The unit
// supports single-cycle branch redirect with squash, and two modes:
//   mode = 1 : unified (lockstep); every lane follows lane 0
//   mode = 0 : split; every lane runs on its own
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   mode                1 = unified, 0 = split
//   br_valid/br_target  per-lane redirect request and target PC
//   imem_en/imem_addr   per-lane memory read enable and address
//   imem_rdata          per-lane read data (one cycle after the enabled address)
//   out_valid/out_ready per-lane instruction handshake
//   out_instr/out_pc    per-lane instruction word and its PC
//
// Optional build macro FETCH_PERF_EN adds perf_fetched and perf_squashed,
// per-lane 32-bit saturating counters of accepted and squashed fetches.
module lane_fetch_unit #(
    parameter int unsigned          LANES       = 2,
    parameter int unsigned          PC_W        = 32,
    parameter logic [PC_W-1:0]      RESET_PC    = {PC_W{1'b0}},
    parameter int unsigned          LANE_STRIDE = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [LANES-1:0]        br_valid,
    input  logic [LANES*PC_W-1:0]   br_target,
    output logic [LANES-1:0]        imem_en,
    output logic [LANES*PC_W-1:0]   imem_addr,
    input  logic [LANES*32-1:0]     imem_rdata,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [LANES*32-1:0]     out_instr,
    output logic [LANES*PC_W-1:0]   out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [LANES*32-1:0]     perf_fetched,
    output logic [LANES*32-1:0]     perf_squashed
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Base address offset of a lane in the instruction memory (wraps to PC_W).
    function automatic logic [PC_W-1:0] lane_offset(input int unsigned lane);
        lane_offset = PC_W'(lane * LANE_STRIDE);
    endfunction

`ifdef FETCH_PERF_EN
    // Increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction
`endif

    state_e             state_q    [LANES];
    state_e             state_d    [LANES];
    logic [PC_W-1:0]    fetch_pc_q [LANES];
    logic [PC_W-1:0]    fetch_pc_d [LANES];
    logic [PC_W-1:0]    out_pc_q   [LANES];
    logic [PC_W-1:0]    out_pc_d   [LANES];
    logic [LANES-1:0]   out_valid_q;
    logic [LANES-1:0]   out_valid_d;
    logic               mode_q;

    logic               ready_all_s;
    logic               mode_chg_s;
    logic [LANES-1:0]   ready_eff_s;
    logic [LANES-1:0]   kill_s;
    logic [LANES-1:0]   issue_s;
    logic [PC_W-1:0]    target_s   [LANES];

`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetched_q  [LANES];
    logic [31:0]        perf_fetched_d  [LANES];
    logic [31:0]        perf_squashed_q [LANES];
    logic [31:0]        perf_squashed_d [LANES];
`endif

    // Per-lane handshake qualification, redirect selection and next state.
    // In unified mode every lane sees lane 0's redirect and the AND of all
    // readies; a mode change loads every lane with lane 0's PC, so from then
    // on all lanes hold identical state and advance in lockstep.
    always_comb begin
        ready_all_s = &out_ready;
        mode_chg_s  = (mode != mode_q);
        for (int l = 0; l < LANES; l++) begin
            ready_eff_s[l] = mode ? ready_all_s : out_ready[l];
            kill_s[l]      = mode_chg_s | (mode ? br_valid[0] : br_valid[l]);
            if (mode_chg_s) begin
                target_s[l] = fetch_pc_q[0];
            end else if (mode) begin
                target_s[l] = br_target[0 +: PC_W];
            end else begin
                target_s[l] = br_target[l*PC_W +: PC_W];
            end

            // A new fetch is only issued when the output slot will be free at
            // the next edge; otherwise the memory would overwrite a word the
            // consumer has not taken yet.
            case (state_q[l])
                ST_RUN, ST_FLUSH: issue_s[l] = ~(out_valid_q[l] & ~ready_eff_s[l]);
                default:          issue_s[l] = 1'b0;
            endcase

            state_d[l]     = state_q[l];
            fetch_pc_d[l]  = fetch_pc_q[l];
            out_pc_d[l]    = out_pc_q[l];
            out_valid_d[l] = out_valid_q[l];

            if (kill_s[l]) begin
                // Redirect wins over HOLD and over a same-cycle handshake.
                state_d[l]     = ST_FLUSH;
                fetch_pc_d[l]  = target_s[l];
                out_valid_d[l] = 1'b0;
            end else begin
                case (state_q[l])
                    ST_IDLE: begin
                        state_d[l] = ST_RUN;
                    end
                    ST_RUN, ST_FLUSH: begin
                        if (issue_s[l]) begin
                            state_d[l]     = ST_RUN;
                            fetch_pc_d[l]  = fetch_pc_q[l] + {{(PC_W-1){1'b0}}, 1'b1};
                            out_pc_d[l]    = fetch_pc_q[l];
                            out_valid_d[l] = 1'b1;
                        end else begin
                            state_d[l] = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (ready_eff_s[l]) begin
                            // Held word is taken now; the next fetch goes out
                            // from RUN on the following cycle.
                            state_d[l]     = ST_RUN;
                            out_valid_d[l] = 1'b0;
                        end else begin
                            state_d[l] = ST_HOLD;
                        end
                    end
                    default: begin
                        state_d[l] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Lane state, PC and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l]    <= ST_IDLE;
                fetch_pc_q[l] <= RESET_PC;
                out_pc_q[l]   <= {PC_W{1'b0}};
            end
            out_valid_q <= {LANES{1'b0}};
            mode_q      <= 1'b0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                state_q[l]    <= state_d[l];
                fetch_pc_q[l] <= fetch_pc_d[l];
                out_pc_q[l]   <= out_pc_d[l];
            end
            out_valid_q <= out_valid_d;
            mode_q      <= mode;
        end
    end

    // Output packing; memory data passes straight through as the instruction.
    always_comb begin
        imem_en   = issue_s;
        out_valid = out_valid_q;
        out_instr = imem_rdata;
        imem_addr = {(LANES*PC_W){1'b0}};
        out_pc    = {(LANES*PC_W){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            imem_addr[l*PC_W +: PC_W] = fetch_pc_q[l] + lane_offset(l);
            out_pc[l*PC_W +: PC_W]    = out_pc_q[l];
        end
    end

`ifdef FETCH_PERF_EN
    // Next values of the performance counters.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (out_valid_q[l] & ready_eff_s[l]) begin
                perf_fetched_d[l] = sat_inc(perf_fetched_q[l]);
            end else begin
                perf_fetched_d[l] = perf_fetched_q[l];
            end
            if (issue_s[l] & kill_s[l]) begin
                perf_squashed_d[l] = sat_inc(perf_squashed_q[l]);
            end else begin
                perf_squashed_d[l] = perf_squashed_q[l];
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                perf_fetched_q[l]  <= 32'd0;
                perf_squashed_q[l] <= 32'd0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                perf_fetched_q[l]  <= perf_fetched_d[l];
                perf_squashed_q[l] <= perf_squashed_d[l];
            end
        end
    end

    // Counter output packing.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            perf_fetched[l*32 +: 32]  = perf_fetched_q[l];
            perf_squashed[l*32 +: 32] = perf_squashed_q[l];
        end
    end
`endif

endmodule
